// File: rtl/imm_pkg.sv
// Shared encodings for the immediate-generation stage: select codes,
// default datapath width and the skid-buffer state encoding.
package imm_pkg;

  localparam int IMM_XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_SHAMT = 3'b001,
    IMM_S     = 3'b010,
    IMM_B     = 3'b011,
    IMM_U     = 3'b100,
    IMM_J     = 3'b101,
    IMM_CSR   = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: instr + select -> XLEN immediate.
// Define IMM_ZICSR_EN to decode select 110 as the CSR zimm field.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = IMM_XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_select,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Opcode bits never feed an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Sign fill first, then overwrite the low field; avoids zero-width
  // replications when XLEN equals the field span.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_select)
      IMM_I: begin
        imm       = {XLEN{instr[31]}};
        imm[11:0] = instr[31:20];
      end
      IMM_SHAMT: begin
        imm      = '0;
        imm[4:0] = instr[24:20];
        if (XLEN == 64) imm[5] = instr[25];
      end
      IMM_S: begin
        imm       = {XLEN{instr[31]}};
        imm[11:0] = {instr[31:25], instr[11:7]};
      end
      IMM_B: begin
        imm       = {XLEN{instr[31]}};
        imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      IMM_U: begin
        imm       = {XLEN{instr[31]}};
        imm[31:0] = {instr[31:12], 12'b0};
      end
      IMM_J: begin
        imm       = {XLEN{instr[31]}};
        imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
`ifdef IMM_ZICSR_EN
      IMM_CSR: begin
        imm      = '0;
        imm[4:0] = instr[19:15];
      end
`endif
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: decode in front of a 2-entry skid buffer
// with a registered in_ready. Optional CSR zimm decode via IMM_ZICSR_EN.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = IMM_XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_select,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic             illegal;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, skid_q, dec_e;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;
  logic             accept, consume;
  logic             load_main, load_skid, main_from_skid;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr      (instr),
    .imm_select (imm_select),
    .imm        (dec_imm),
    .illegal    (dec_ill)
  );

  assign dec_e   = '{illegal: dec_ill, tag: in_tag, imm: dec_imm};
  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  assign out_valid   = (state_q != ST_EMPTY);
  assign out_imm     = main_q.imm;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.illegal;

  // Next state and register-load steering; flush overrides all moves.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_MAIN;
          load_main = 1'b1;
        end
      end
      ST_MAIN: begin
        case ({accept, consume})
          2'b10: begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end
          2'b11: load_main = 1'b1;
          2'b01: state_d   = ST_EMPTY;
          default: ;
        endcase
      end
      ST_FULL: begin
        if (consume) begin
          state_d        = ST_MAIN;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // State, data registers and registered ready; reset wins over flush.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != ST_FULL);
      if (load_main)           main_q <= dec_e;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec_e;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: a 32-bit and a 64-bit instance share
// stimulus; a vector table covers decode, hand sequences cover the buffer.
module tb_imm_gen_stage;

  localparam int TAG_W = 5;

  logic             CLK = 1'b0;
  logic             RESET, flush, in_valid, out_ready;
  logic [31:0]      instr;
  logic [2:0]       imm_select;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready32, out_valid32, out_illegal32;
  logic [31:0]      out_imm32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64, out_illegal64;
  logic [63:0]      out_imm64;
  logic [TAG_W-1:0] out_tag64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .CLK(CLK), .RESET(RESET), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .instr(instr), .imm_select(imm_select),
    .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .CLK(CLK), .RESET(RESET), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .instr(instr), .imm_select(imm_select),
    .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [2:0] sel, input logic [31:0] ins, input logic [TAG_W-1:0] tag);
    in_valid   = 1'b1;
    imm_select = sel;
    instr      = ins;
    in_tag     = tag;
  endtask

  initial begin
    vecs[0] = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'h7FF00093, 3'b000, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[2] = '{32'hFE000EE3, 3'b011, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3] = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFFD, 1'b0};
    vecs[4] = '{32'h7E000FA3, 3'b010, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[5] = '{32'h800000B7, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[6] = '{32'h03F00013, 3'b001, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vecs[7] = '{32'h7FFFF06F, 3'b101, 32'h000FFFFE, 64'h00000000000FFFFE, 1'b0};
    vecs[8] = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1};
`ifdef IMM_ZICSR_EN
    vecs[9] = '{32'h000F8073, 3'b110, 32'h0000001F, 64'h000000000000001F, 1'b0};
`else
    vecs[9] = '{32'h000F8073, 3'b110, 32'h00000000, 64'h0000000000000000, 1'b1};
`endif

    RESET = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; imm_select = '0; in_tag = '0;
    tick(); tick();
    chk("rst_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready32}, 64'd1);
    chk("rst_out_imm", {32'b0, out_imm32}, 64'd0);
    chk("rst_out_tag", {59'b0, out_tag32}, 64'd0);
    chk("rst_out_illegal", {63'b0, out_illegal32}, 64'd0);
    chk("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
    RESET = 1'b0;
    tick();

    // Decode table: one entry per two cycles, out_ready held high.
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].sel, vecs[i].instr, TAG_W'(i + 1));
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid32", i), {63'b0, out_valid32}, 64'd1);
      chk($sformatf("v%0d_imm32", i), {32'b0, out_imm32}, {32'b0, vecs[i].e32});
      chk($sformatf("v%0d_ill32", i), {63'b0, out_illegal32}, {63'b0, vecs[i].ill});
      chk($sformatf("v%0d_tag32", i), {59'b0, out_tag32}, 64'(i + 1));
      chk($sformatf("v%0d_imm64", i), out_imm64, vecs[i].e64);
      chk($sformatf("v%0d_ill64", i), {63'b0, out_illegal64}, {63'b0, vecs[i].ill});
      tick();
      chk($sformatf("v%0d_drain", i), {63'b0, out_valid32}, 64'd0);
    end

    // Backpressure: tags 1,2 fill the buffer, tag 3 must wait.
    out_ready = 1'b0;
    push(3'b000, 32'h00100093, 5'd1);
    tick();
    chk("bp_ready_after1", {63'b0, in_ready32}, 64'd1);
    push(3'b000, 32'h00200093, 5'd2);
    tick();
    chk("bp_ready_full", {63'b0, in_ready32}, 64'd0);
    push(3'b000, 32'h00300093, 5'd3);
    tick();
    chk("bp_hold_tag", {59'b0, out_tag32}, 64'd1);
    chk("bp_hold_imm", {32'b0, out_imm32}, 64'd1);
    chk("bp_still_full", {63'b0, in_ready32}, 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_tag2", {59'b0, out_tag32}, 64'd2);
    chk("bp_imm2", {32'b0, out_imm32}, 64'd2);
    chk("bp_ready_again", {63'b0, in_ready32}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_tag3", {59'b0, out_tag32}, 64'd3);
    chk("bp_imm3", {32'b0, out_imm32}, 64'd3);
    chk("bp_valid3", {63'b0, out_valid32}, 64'd1);
    tick();
    chk("bp_empty", {63'b0, out_valid32}, 64'd0);

    // Flush while FULL with a simultaneous input.
    out_ready = 1'b0;
    push(3'b000, 32'h00400093, 5'd4);
    tick();
    push(3'b000, 32'h00500093, 5'd5);
    tick();
    chk("fl_full", {63'b0, in_ready32}, 64'd0);
    push(3'b000, 32'h00600093, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {63'b0, out_valid32}, 64'd0);
    chk("fl_ready", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", {63'b0, out_valid32}, 64'd0);

    // Flush with an input in EMPTY: the input is dropped.
    push(3'b000, 32'h00700093, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_empty_drop", {63'b0, out_valid32}, 64'd0);

    // Reset mid-operation, together with flush and an input.
    out_ready = 1'b0;
    push(3'b101, 32'h7FFFF06F, 5'd8);
    tick();
    push(3'b000, 32'h00900093, 5'd9);
    RESET = 1'b1; flush = 1'b1;
    tick();
    RESET = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("mr_valid", {63'b0, out_valid32}, 64'd0);
    chk("mr_ready", {63'b0, in_ready32}, 64'd1);
    chk("mr_imm", {32'b0, out_imm32}, 64'd0);
    chk("mr_tag", {59'b0, out_tag32}, 64'd0);
    out_ready = 1'b1;
    tick();
    chk("mr_stay_empty", {63'b0, out_valid32}, 64'd0);

    // Post-reset single-cycle latency.
    push(3'b100, 32'h800000B7, 5'd10);
    tick();
    in_valid = 1'b0;
    chk("lat_valid", {63'b0, out_valid32}, 64'd1);
    chk("lat_imm64", out_imm64, 64'hFFFFFFFF80000000);
    chk("lat_tag64", {59'b0, out_tag64}, 64'd10);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
